// File: rtl/game_pkg.sv
// game_pkg: shared state encoding and BCD digit width for the game sequencer
package game_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_CLEAR = 2'd2,
        ST_OVER  = 2'd3
    } state_t;
    localparam int BCD_W = 4;
endpackage

// File: rtl/bcd_counter.sv
// bcd_counter: multi-digit BCD incrementer with synchronous clear and saturation at all 9s
module bcd_counter
    import game_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                      board_clk,
    input  logic                      reset,
    input  logic                      inc,
    input  logic                      clr,
    output logic [BCD_W*DIGITS-1:0]   count
);
    logic [BCD_W*DIGITS-1:0] count_nxt;
    logic                    carry;
    logic                    full;

    // ripple a decimal carry from digit 0 upward; a carry out of the top digit means all 9s
    always_comb begin
        count_nxt = count;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            count_nxt[BCD_W*i +: BCD_W] = carry ? (count[BCD_W*i +: BCD_W] == 4'd9 ? 4'd0 : count[BCD_W*i +: BCD_W] + 4'd1) : count[BCD_W*i +: BCD_W];
            carry = carry && count[BCD_W*i +: BCD_W] == 4'd9;
        end
        full = carry;
    end

    // hold the count once saturated so the score never wraps to zero
    always_ff @(posedge board_clk) begin
        if (reset || clr) count <= '0;
        else if (inc && !full) count <= count_nxt;
    end
endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: game-flow FSM owning score, lives and level, plus tick and pixel enable generation
module game_sequencer
    import game_pkg::*;
#(
    parameter int TICK_DIV     = 2097152,
    parameter int PIX_DIV      = 4,
    parameter int NUM_LIVES    = 3,
    parameter int NUM_LEVELS   = 4,
    parameter int SCORE_DIGITS = 4,
    parameter int HOLD_CYCLES  = 50000000,
    localparam int LW = NUM_LEVELS > 1 ? $clog2(NUM_LEVELS) : 1,
    localparam int VW = $clog2(NUM_LIVES + 1)
) (
    input  logic                      board_clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      hit_pulse,
    input  logic                      player_hit,
    input  logic                      aliens_defeated,
    input  logic                      reached_bottom,
    output logic                      pix_en,
    output logic                      game_tick,
    output logic                      game_rst,
    output logic [1:0]                state,
    output logic [LW-1:0]             level,
    output logic [VW-1:0]             lives,
    output logic [BCD_W*SCORE_DIGITS-1:0] score,
    output logic                      win
);
    localparam int PW = PIX_DIV > 1 ? $clog2(PIX_DIV) : 1;

    state_t        cur, nxt;
    logic [LW-1:0] level_nxt;
    logic [VW-1:0] lives_nxt;
    logic          win_nxt, rst_nxt, score_clr, score_inc, start_rise;
    logic [31:0]   tick_cnt, tick_nxt, hold_cnt, hold_nxt, period;
    logic [PW-1:0] pix_cnt;
    logic [2:0]    sync;

    assign state      = cur;
    assign start_rise = sync[1] && !sync[2];
    assign period     = (32'(TICK_DIV) >> level) == 32'd0 ? 32'd1 : 32'(TICK_DIV) >> level;
    assign pix_en     = pix_cnt == PW'(PIX_DIV - 1);
    assign game_tick  = cur == ST_PLAY && !game_rst && tick_cnt == period - 32'd1;
    assign score_inc  = hit_pulse && cur == ST_PLAY;

    // start synchroniser with edge-detect flop, and the free-running pixel divider
    always_ff @(posedge board_clk) begin
        sync    <= reset ? 3'b000 : {sync[1:0], start};
        pix_cnt <= (reset || pix_en) ? '0 : pix_cnt + PW'(1);
    end

    // game state register; reset aborts the game with no pulse afterwards
    always_ff @(posedge board_clk) begin
        if (reset) begin
            cur      <= ST_IDLE;
            level    <= '0;
            lives    <= VW'(NUM_LIVES);
            win      <= 1'b0;
            game_rst <= 1'b0;
            tick_cnt <= '0;
            hold_cnt <= '0;
        end else begin
            cur      <= nxt;
            level    <= level_nxt;
            lives    <= lives_nxt;
            win      <= win_nxt;
            game_rst <= rst_nxt;
            tick_cnt <= tick_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    // next-state logic; counters default to zero so any state exit clears them
    always_comb begin
        nxt       = cur;
        level_nxt = level;
        lives_nxt = lives;
        win_nxt   = win;
        rst_nxt   = 1'b0;
        score_clr = 1'b0;
        tick_nxt  = '0;
        hold_nxt  = '0;
        case (cur)
            ST_IDLE, ST_OVER: begin
                if (start_rise) begin
                    nxt       = ST_PLAY;
                    level_nxt = '0;
                    lives_nxt = VW'(NUM_LIVES);
                    win_nxt   = 1'b0;
                    rst_nxt   = 1'b1;
                    score_clr = 1'b1;
                end
            end
            ST_PLAY: begin
                tick_nxt = (game_rst || game_tick) ? '0 : tick_cnt + 32'd1;
                if (aliens_defeated) begin
                    nxt      = ST_CLEAR;
                    tick_nxt = '0;
                end else if (player_hit || (reached_bottom && !game_rst)) begin
                    tick_nxt = '0;
                    if (lives == VW'(1)) begin
                        lives_nxt = '0;
                        nxt       = ST_OVER;
                        win_nxt   = 1'b0;
                    end else begin
                        lives_nxt = lives - VW'(1);
                        rst_nxt   = 1'b1;
                    end
                end
            end
            default: begin
                hold_nxt = hold_cnt + 32'd1;
                if (hold_cnt == 32'(HOLD_CYCLES - 1)) begin
                    hold_nxt = '0;
                    if (level == LW'(NUM_LEVELS - 1)) begin
                        nxt     = ST_OVER;
                        win_nxt = 1'b1;
                    end else begin
                        nxt       = ST_PLAY;
                        level_nxt = level + LW'(1);
                        rst_nxt   = 1'b1;
                    end
                end
            end
        endcase
    end

    bcd_counter #(.DIGITS(SCORE_DIGITS)) u_score (
        .board_clk (board_clk),
        .reset     (reset),
        .inc       (score_inc),
        .clr       (score_clr),
        .count     (score)
    );
endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: scoreboard-driven check of game flow, scoring, lives, levels and enables
module tb_game_sequencer;
    localparam int S_STATE = 0, S_LIVES = 1, S_SCORE = 2, S_LEVEL = 3, S_WIN = 4, S_RST = 5;

    typedef struct {
        int          sel;
        logic [31:0] val;
    } exp_t;

    logic       board_clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0, hit_pulse = 1'b0, player_hit = 1'b0;
    logic       aliens_defeated = 1'b0, reached_bottom = 1'b0;
    logic       pix_en, game_tick, game_rst, win;
    logic [1:0] state;
    logic [0:0] level;
    logic [1:0] lives;
    logic [7:0] score;

    int         total = 0;
    int         bad = 0;
    exp_t       sb[$];
    logic [7:0] model_score = 8'h00;

    game_sequencer #(
        .TICK_DIV(16), .PIX_DIV(4), .NUM_LIVES(2), .NUM_LEVELS(2),
        .SCORE_DIGITS(2), .HOLD_CYCLES(8)
    ) dut (
        .board_clk(board_clk), .reset(reset), .start(start), .hit_pulse(hit_pulse),
        .player_hit(player_hit), .aliens_defeated(aliens_defeated),
        .reached_bottom(reached_bottom), .pix_en(pix_en), .game_tick(game_tick),
        .game_rst(game_rst), .state(state), .level(level), .lives(lives),
        .score(score), .win(win)
    );

    always #5 board_clk = ~board_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] obs(input int sel);
        case (sel)
            S_STATE: return 32'(state);
            S_LIVES: return 32'(lives);
            S_SCORE: return 32'(score);
            S_LEVEL: return 32'(level);
            S_WIN:   return 32'(win);
            default: return 32'(game_rst);
        endcase
    endfunction

    function automatic string nm(input int sel);
        case (sel)
            S_STATE: return "state";
            S_LIVES: return "lives";
            S_SCORE: return "score";
            S_LEVEL: return "level";
            S_WIN:   return "win";
            default: return "game_rst";
        endcase
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v == 8'h99) return v;
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    task automatic push(input int sel, input logic [31:0] v);
        sb.push_back('{sel, v});
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(nm(e.sel), obs(e.sel), e.val);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge board_clk);
    endtask

    task automatic wait_state(input logic [1:0] s, input int lim);
        int n = 0;
        while (state !== s && n < lim) begin
            cyc(1);
            n++;
        end
        check("wait_state", 32'(state), 32'(s));
    endtask

    task automatic hit(input bit in_play);
        hit_pulse = 1'b1;
        if (in_play) model_score = bcd_inc(model_score);
        push(S_SCORE, 32'(model_score));
        cyc(1);
        hit_pulse = 1'b0;
        drain();
    endtask

    task automatic restart();
        start = 1'b0;
        cyc(4);
        start = 1'b1;
        wait_state(2'd1, 4);
        model_score = 8'h00;
        push(S_RST, 1);
        push(S_SCORE, 0);
        push(S_LIVES, 2);
        push(S_LEVEL, 0);
        push(S_WIN, 0);
        drain();
    endtask

    task automatic tick_gap(input int n, output int gap);
        int last = -1;
        gap = 0;
        for (int i = 0; i < n; i++) begin
            cyc(1);
            if (game_tick) begin
                if (last >= 0) gap = i - last;
                last = i;
            end
        end
    endtask

    task automatic clear_len(output int n);
        n = 1;
        while (state == 2'd2 && n < 20) begin
            cyc(1);
            if (state == 2'd2) n++;
        end
    endtask

    // the tick and restart pulses must never overlap
    always @(negedge board_clk) begin
        if (game_rst && game_tick) check("rst_tick_overlap", 1, 0);
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int np, nt, gap, n;
        cyc(3);
        push(S_STATE, 0); push(S_LIVES, 2); push(S_SCORE, 0);
        push(S_LEVEL, 0); push(S_WIN, 0); push(S_RST, 0);
        drain();
        check("reset_tick", 32'(game_tick), 0);
        check("reset_pix", 32'(pix_en), 0);
        reset = 1'b0;
        np = 0;
        nt = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            np += int'(pix_en);
            nt += int'(game_tick);
        end
        check("idle_pix_count", np, 5);
        check("idle_tick_count", nt, 0);
        check("idle_state", 32'(state), 0);
        restart();
        cyc(1);
        check("rst_one_cycle", 32'(game_rst), 0);
        tick_gap(40, gap);
        check("tick_gap_l0", gap, 16);
        for (int i = 0; i < 12; i++) hit(1'b1);
        check("score_12", 32'(score), 32'h12);
        for (int i = 0; i < 100; i++) hit(1'b1);
        check("score_sat", 32'(score), 32'h99);
        player_hit = 1'b1;
        push(S_LIVES, 1); push(S_STATE, 1); push(S_RST, 1);
        cyc(1);
        player_hit = 1'b0;
        drain();
        cyc(1);
        check("rst_after_hit", 32'(game_rst), 0);
        reached_bottom = 1'b1;
        push(S_LIVES, 0); push(S_STATE, 3); push(S_WIN, 0);
        cyc(1);
        reached_bottom = 1'b0;
        drain();
        hit(1'b0);
        restart();
        cyc(2);
        aliens_defeated = 1'b1;
        hit_pulse = 1'b1;
        model_score = bcd_inc(model_score);
        push(S_STATE, 2); push(S_SCORE, 32'(model_score)); push(S_LIVES, 2);
        cyc(1);
        aliens_defeated = 1'b0;
        hit_pulse = 1'b0;
        drain();
        clear_len(n);
        check("clear_len_l0", n, 8);
        push(S_STATE, 1); push(S_LEVEL, 1); push(S_RST, 1);
        drain();
        tick_gap(30, gap);
        check("tick_gap_l1", gap, 8);
        aliens_defeated = 1'b1;
        cyc(1);
        aliens_defeated = 1'b0;
        check("clear_enter_l1", 32'(state), 2);
        clear_len(n);
        check("clear_len_l1", n, 8);
        push(S_STATE, 3); push(S_WIN, 1); push(S_LEVEL, 1);
        drain();
        restart();
        cyc(2);
        hit(1'b1);
        aliens_defeated = 1'b1;
        player_hit = 1'b1;
        push(S_STATE, 2); push(S_LIVES, 2);
        cyc(1);
        aliens_defeated = 1'b0;
        player_hit = 1'b0;
        drain();
        cyc(3);
        reset = 1'b1;
        push(S_STATE, 0); push(S_LEVEL, 0); push(S_SCORE, 0); push(S_LIVES, 2);
        cyc(1);
        drain();
        check("abort_rst", 32'(game_rst), 0);
        check("abort_tick", 32'(game_tick), 0);
        reset = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
